// File: rtl/easyaxi_slv_rd.sv
// -----------------------------------------------------------------------------
// easyaxi_slv_rd
//   AXI4 read-channel responder for the EASYAXI subsystem. It accepts one AR
//   request at a time and returns an R burst. Each beat's data is that beat's
//   byte address, zero-extended to DATA_WIDTH. No backing memory is needed, and
//   every read can be checked against its own address.
//
// Optional build macro:
//   EASYAXI_SLV_RD_RESP_EN - per-beat response checking.
//     * DECERR (11) for a beat whose address is >= ADDR_RANGE.
//     * SLVERR (10) for the whole burst when arsize exceeds the bus width.
//     * DECERR takes priority over SLVERR.
//     * Error beats carry rdata = 0.
//   When the macro is undefined, rresp is tied to OKAY (00).
//
// Parameters:
//   ADDR_WIDTH - araddr width in bits
//   DATA_WIDTH - rdata width in bits (power of two, 8..128)
//   ID_WIDTH   - arid / rid width
//   ADDR_RANGE - valid byte window [0, ADDR_RANGE), used only with the macro
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   enable              - high allows new AR requests to be accepted
//   arvalid/arready     - AR handshake
//   arid, araddr, arlen,
//   arsize, arburst     - AR payload
//   rvalid/rready       - R handshake
//   rid, rdata, rresp,
//   rlast               - R payload (all registered)
// -----------------------------------------------------------------------------
module easyaxi_slv_rd #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_RANGE = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef EASYAXI_SLV_RD_RESP_EN
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] MAX_SIZE    = 3'($clog2(DATA_WIDTH / 8));
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;   // byte address of the beat currently on R
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;    // index of the beat currently on R
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic [7:0]            w_cnt_next;
  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic                  w_wrap_legal;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [1:0]            w_first_resp;
  logic [1:0]            w_next_resp;

  assign w_ar_hs    = (r_state == ST_IDLE) && arvalid && r_arready;
  assign w_r_hs     = r_rvalid && rready;
  assign w_cnt_next = r_cnt + 8'd1;

  // Next beat address. WRAP only wraps for 2, 4, 8 or 16 beats. Any other
  // length, and the reserved encoding 11, behave as INCR.
  always_comb begin
    // NOTE: every signal gets a default before the case. A path that leaves
    // a combinational output unassigned would infer a latch.
    w_step       = ADDR_WIDTH'(1) << r_size;
    // The wrap container is (len+1) * step bytes. The mask is container - 1.
    w_wrap_mask  = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
    w_wrap_legal = (r_len == 8'd1) || (r_len == 8'd3) ||
                   (r_len == 8'd7) || (r_len == 8'd15);
    w_next_addr  = r_addr + w_step;
    case (r_burst)
      BURST_FIXED: w_next_addr = r_addr;
      BURST_WRAP: begin
        if (w_wrap_legal) begin
          w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
        end
      end
      default: ;
    endcase
  end

`ifdef EASYAXI_SLV_RD_RESP_EN
  // An out-of-window address outranks an oversized beat.
  function automatic logic [1:0] beat_resp(input logic [ADDR_WIDTH-1:0] addr,
                                           input logic [2:0]            size);
    if (64'(addr) >= 64'(ADDR_RANGE)) return RESP_DECERR;
    if (size > MAX_SIZE)              return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  assign w_first_resp = beat_resp(araddr, arsize);
  assign w_next_resp  = beat_resp(w_next_addr, r_size);
`else
  assign w_first_resp = RESP_OKAY;
  assign w_next_resp  = RESP_OKAY;
`endif

  // Error beats return zero data. Without response checking, resp is always
  // OKAY and this mux reduces to the zero-extended address.
  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [1:0]            resp);
    return (resp == RESP_OKAY) ? DATA_WIDTH'(addr) : '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM. Every output is registered.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_arready <= enable;
          if (w_ar_hs) begin
            // Latch the request. The first beat is presented next cycle.
            r_state   <= ST_BURST;
            r_arready <= 1'b0;
            r_id      <= arid;
            r_addr    <= araddr;
            r_len     <= arlen;
            r_size    <= arsize;
            r_burst   <= arburst;
            r_cnt     <= 8'd0;
            r_rvalid  <= 1'b1;
            r_rlast   <= (arlen == 8'd0);
            r_rresp   <= w_first_resp;
            r_rdata   <= beat_data(araddr, w_first_resp);
          end
        end

        ST_BURST: begin
          // Without a handshake, every R payload register holds its value.
          if (w_r_hs) begin
            if (r_rlast) begin
              r_state   <= ST_IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              // This gives a single idle cycle between bursts when enable is high.
              r_arready <= enable;
            end else begin
              r_addr    <= w_next_addr;
              r_cnt     <= w_cnt_next;
              r_rlast   <= (w_cnt_next == r_len);
              r_rresp   <= w_next_resp;
              r_rdata   <= beat_data(w_next_addr, w_next_resp);
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rid     = r_id;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;

endmodule

// File: doc/easyaxi_slv_rd.md
Name: easyaxi_slv_rd

Overview:
- AXI4 read-channel responder (slave) for the EASYAXI subsystem. It accepts read-address requests and returns R-channel data bursts.
- It is the far end of the read channels that the EASYAXI master drives. It serves as the bench and bring-up target inside the EASYAXI top.
- Read data is a deterministic function of each beat's byte address, so no backing memory is needed and any read is self-checking.

Parameters:
- ADDR_WIDTH, 16, width of araddr in bits.
- DATA_WIDTH, 32, width of rdata in bits; power of two, 8..128.
- ID_WIDTH, 4, width of arid/rid.
- ADDR_RANGE, 4096, valid address window [0, ADDR_RANGE) in bytes; used only by the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  high = slave may accept new AR requests
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- arid  in  ID_WIDTH  transaction ID
- araddr  in  ADDR_WIDTH  start byte address
- arlen  in  8  beats minus one
- arsize  in  3  log2 bytes per beat
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- rvalid  out  1  R valid
- rready  in  1  R ready
- rid  out  ID_WIDTH  echo of arid
- rdata  out  DATA_WIDTH  beat data
- rresp  out  2  response
- rlast  out  1  final beat

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous assert, active-low. Release is synchronous to clk, handled by the top.
- Reset values: arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0. FSM in IDLE; beat counter and address register at 0.
- FSM states: IDLE, BURST.
  - IDLE: arready = enable (registered, so it updates the cycle after enable changes).
  - IDLE -> BURST on arvalid && arready. Latch arid, araddr, arlen, arsize, arburst; beat counter = 0; drop arready.
  - BURST: rvalid=1 from the cycle after the AR handshake (first-beat latency 1 cycle).
  - Each cycle with rvalid && rready: advance address, counter += 1.
  - rlast = 1 when counter == latched arlen.
  - Handshake on the rlast beat -> IDLE. arready re-asserts the next cycle if enable=1; the minimum gap between bursts is 1 cycle.
- Outstanding: exactly one transaction; no AR is accepted during BURST.
- AXI stability: once rvalid is high, rdata, rresp, rid and rlast stay stable until rready. rvalid never drops without a handshake.
- Address update per beat, with step = 1<<arsize:
  - FIXED: address unchanged.
  - INCR: address += step, wrapping modulo 2^ADDR_WIDTH.
  - WRAP: container = (arlen+1)*step. Next = (addr & ~(container-1)) | ((addr+step) & (container-1)). Legal only for arlen in {1,3,7,15}; other lengths are treated as INCR.
- Data: rdata = current beat byte address zero-extended to DATA_WIDTH, in all lanes, regardless of arsize.
- rresp = 00 OKAY (when the optional feature is absent).
- rready stalls: no limit on length; the counter and address hold.
- enable low during BURST: the current burst completes; only new acceptance is blocked.
- Reset mid-burst: all outputs go to reset values immediately; the partial burst is discarded.
- arlen=255: 256 beats; the counter is 8 bits and compares equal at 255 without overflow.

Optional Feature:
- Macro: EASYAXI_SLV_RD_RESP_EN.
- Defined: per-beat response checking.
  - rresp = 11 DECERR for a beat whose address is >= ADDR_RANGE.
  - rresp = 10 SLVERR for the whole burst if arsize > log2(DATA_WIDTH/8).
  - DECERR takes priority over SLVERR.
  - Error beats carry rdata=0. The burst length and rlast are unchanged.
- Undefined: rresp is tied to 00 and no range or size logic is synthesized.

Test Plan:
- Reset then enable=1; AR INCR addr=0x0010, arlen=3, arsize=2, id=5, rready=1 -> arready high before handshake. rvalid the next cycle; rdata 0x10, 0x14, 0x18, 0x1C; rid=5 on every beat; rlast on the 4th beat only; arready returns 1 cycle after the last beat.
- WRAP addr=0x0038, arlen=3, arsize=2 -> beats 0x38, 0x3C, 0x30, 0x34.
- FIXED addr=0x0100, arlen=2 -> three beats of 0x100, rlast on the 3rd.
- INCR arlen=1 with rready held low 5 cycles after rvalid -> rvalid, rdata and rlast=0 stable throughout; both beats are delivered afterwards.
- Assert rst_n=0 at beat 2 of an arlen=7 burst -> rvalid=0 and arready=0 asynchronously. After release, a new AR completes normally. Also: with enable=0, arvalid held for 10 cycles -> never accepted.
- With EASYAXI_SLV_RD_RESP_EN defined and ADDR_RANGE=4096:
  - INCR addr=0x0FFC, arlen=1, arsize=2 -> beat 0: OKAY, rdata 0xFFC; beat 1: DECERR, rdata 0.
  - arsize=3 -> all beats SLVERR.
